// File: rtl/sa_top_skew.sv
// sa_top_skew: tile-level wrapper around an output-stationary systolic core.
//   Beats (A1 row operands, B1 column operands) are accepted with a
//   valid/ready handshake and registered once into a stage register. Each lane
//   is then skewed so that operands of the same beat meet inside the array. An
//   FSM closes the tile on in_last, or on the KMAX-th beat (which also sets the
//   sticky overflow flag). It then waits for the array to drain, captures the
//   result into YY1, pulses out_valid and clears the core for the next tile.
// Ports:
//   CLK, RST     - clock and synchronous active-high reset
//   in_valid/in_ready/in_last, A1, B1 - beat handshake and operands
//   YY1          - registered tile result, element (r,c) at index r*HPE+c
//   out_valid    - one-cycle pulse when YY1 has just been updated
//   busy         - tile in progress
//   overflow     - sticky: a tile hit KMAX beats without in_last

// sa_2D: VPE x HPE output-stationary MAC array. A flows right along rows and
//   B flows down columns, one PE per cycle. Each PE accumulates a*b into a
//   2*WIDTH wrapping accumulator, and the accumulators are driven out on YY.
module sa_2D #(
    parameter int HPE   = 4,
    parameter int VPE   = 4,
    parameter int WIDTH = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [WIDTH*VPE-1:0]         A,
    input  logic [WIDTH*HPE-1:0]         B,
    output logic [2*WIDTH*HPE*VPE-1:0]   YY
);
    logic [WIDTH-1:0]   r_a   [VPE][HPE];
    logic [WIDTH-1:0]   r_b   [VPE][HPE];
    logic [2*WIDTH-1:0] r_acc [VPE][HPE];
    logic [WIDTH-1:0]   w_a_in[VPE][HPE];
    logic [WIDTH-1:0]   w_b_in[VPE][HPE];

    for (genvar r = 0; r < VPE; r++) begin : g_row
        for (genvar c = 0; c < HPE; c++) begin : g_col
            if (c == 0) begin : g_a_edge
                assign w_a_in[r][c] = A[r*WIDTH +: WIDTH];
            end else begin : g_a_inner
                assign w_a_in[r][c] = r_a[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign w_b_in[r][c] = B[c*WIDTH +: WIDTH];
            end else begin : g_b_inner
                assign w_b_in[r][c] = r_b[r-1][c];
            end
            assign YY[(r*HPE+c)*2*WIDTH +: 2*WIDTH] = r_acc[r][c];
        end
    end

    // Operand forwarding and multiply-accumulate in every PE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < VPE; r++) begin
                for (int c = 0; c < HPE; c++) begin
                    r_a[r][c]   <= '0;
                    r_b[r][c]   <= '0;
                    r_acc[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < VPE; r++) begin
                for (int c = 0; c < HPE; c++) begin
                    r_a[r][c]   <= w_a_in[r][c];
                    r_b[r][c]   <= w_b_in[r][c];
                    r_acc[r][c] <= r_acc[r][c] +
                                   ((2*WIDTH)'(w_a_in[r][c]) * (2*WIDTH)'(w_b_in[r][c]));
                end
            end
        end
    end
endmodule

module sa_top_skew #(
    parameter int HPE      = 4,
    parameter int VPE      = 4,
    parameter int WIDTH    = 32,
    parameter int KMAX     = 256,
    parameter int CORE_LAT = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [WIDTH*VPE-1:0]         A1,
    input  logic [WIDTH*HPE-1:0]         B1,
    output logic [2*WIDTH*HPE*VPE-1:0]   YY1,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overflow
);
    // Cycles from the last beat sitting in the stage register until the far
    // corner PE holds its final sum.
    localparam int D  = VPE + HPE - 1 + CORE_LAT;
    localparam int KW = $clog2(KMAX + 1);
    localparam int DW = $clog2(D + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        DRAIN   = 3'd2,
        CAPTURE = 3'd3,
        CLEAR   = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic [KW-1:0]                r_k;
    logic [DW-1:0]                r_drain;
    logic                         r_in_ready;
    logic                         r_busy;
    logic                         r_out_valid;
    logic                         r_overflow;
    logic [2*WIDTH*HPE*VPE-1:0]   r_yy;
    logic [WIDTH*VPE-1:0]         r_stage_a;
    logic [WIDTH*HPE-1:0]         r_stage_b;
    logic [WIDTH*VPE-1:0]         w_core_a;
    logic [WIDTH*HPE-1:0]         w_core_b;
    logic [2*WIDTH*HPE*VPE-1:0]   w_core_yy;
    logic                         w_accept;
    logic                         w_k_limit;
    logic                         w_close;
    logic                         w_core_rst;

    assign w_accept  = in_valid & r_in_ready;
    // This beat is the KMAX-th one of the tile.
    assign w_k_limit = (r_k == KW'(KMAX - 1));
    assign w_close   = w_accept & (in_last | w_k_limit);

    // Next-state logic for the tile sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_close ? DRAIN : LOAD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOAD: begin
                if (w_close) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = LOAD;
                end
            end
            DRAIN: begin
                if (r_drain == DW'(D - 1)) begin
                    w_next_state = CAPTURE;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            CAPTURE: w_next_state = CLEAR;
            CLEAR:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register, counters, status flags and the result register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_k         <= '0;
            r_drain     <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_yy        <= '0;
        end else begin
            r_state    <= w_next_state;
            // Ready and busy are decoded from the next state, so they stay registered.
            r_in_ready <= (w_next_state == IDLE) || (w_next_state == LOAD);
            r_busy     <= (w_next_state != IDLE);
            if (r_state == CLEAR) begin
                r_k <= '0;
            end else if (w_accept) begin
                r_k <= r_k + KW'(1);
            end
            if (r_state == DRAIN) begin
                r_drain <= r_drain + DW'(1);
            end else begin
                r_drain <= '0;
            end
            if (w_accept && !in_last && w_k_limit) begin
                r_overflow <= 1'b1;
            end
            r_out_valid <= (r_state == CAPTURE);
            if (r_state == CAPTURE) begin
                r_yy <= w_core_yy;
            end
        end
    end

    // Stage register: zeros in idle cycles, so bubbles add nothing to the sums.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stage_a <= '0;
            r_stage_b <= '0;
        end else if (w_accept) begin
            r_stage_a <= A1;
            r_stage_b <= B1;
        end else begin
            r_stage_a <= '0;
            r_stage_b <= '0;
        end
    end

    // Row lane r is delayed r cycles.
    for (genvar r = 0; r < VPE; r++) begin : g_skew_a
        if (r == 0) begin : g_direct
            assign w_core_a[WIDTH-1:0] = r_stage_a[WIDTH-1:0];
        end else begin : g_delay
            logic [WIDTH-1:0] r_sh [r];
            // Lane delay line.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int i = 0; i < r; i++) r_sh[i] <= '0;
                end else begin
                    r_sh[0] <= r_stage_a[r*WIDTH +: WIDTH];
                    for (int i = 1; i < r; i++) r_sh[i] <= r_sh[i-1];
                end
            end
            assign w_core_a[r*WIDTH +: WIDTH] = r_sh[r-1];
        end
    end

    // Column lane c is delayed c cycles.
    for (genvar c = 0; c < HPE; c++) begin : g_skew_b
        if (c == 0) begin : g_direct
            assign w_core_b[WIDTH-1:0] = r_stage_b[WIDTH-1:0];
        end else begin : g_delay
            logic [WIDTH-1:0] r_sh [c];
            // Lane delay line.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int i = 0; i < c; i++) r_sh[i] <= '0;
                end else begin
                    r_sh[0] <= r_stage_b[c*WIDTH +: WIDTH];
                    for (int i = 1; i < c; i++) r_sh[i] <= r_sh[i-1];
                end
            end
            assign w_core_b[c*WIDTH +: WIDTH] = r_sh[c-1];
        end
    end

    // The core is wiped in CLEAR so the next tile starts from zero sums.
    assign w_core_rst = RST | (r_state == CLEAR);

    sa_2D #(
        .HPE   (HPE),
        .VPE   (VPE),
        .WIDTH (WIDTH)
    ) u_core (
        .CLK (CLK),
        .RST (w_core_rst),
        .A   (w_core_a),
        .B   (w_core_b),
        .YY  (w_core_yy)
    );

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign YY1       = r_yy;
endmodule
